// File: rtl/clock_pkg.sv
// Shared types, constants and BCD helpers for the hours:minutes:seconds clock.
package clock_pkg;

  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, SET_SEC} state_e;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] BCD_U_MAX  = 4'd9;
  localparam logic [3:0] BCD_T_MAX  = 4'd5;
  localparam logic [7:0] BCD_HR_MAX = 8'h23;

  // Increment a 00..59 BCD pair; result is {wrap, tens, units}.
  function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
    if (v[3:0] != BCD_U_MAX) return {1'b0, v[7:4], v[3:0] + 4'd1};
    if (v[7:4] != BCD_T_MAX) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return 9'h100;
  endfunction

  function automatic logic [7:0] bcd24_inc(input logic [7:0] v);
    if (v == BCD_HR_MAX) return 8'h00;
    if (v[3:0] == BCD_U_MAX) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 24-hour BCD hour to 12-hour BCD hour (00 -> 12, 13..23 -> 01..11).
  function automatic logic [7:0] hr_to_12(input logic [7:0] hr);
    logic [4:0] b;
    b = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
    if (b == 5'd0) b = 5'd12;
    else if (b > 5'd12) b = b - 5'd12;
    return {(b >= 5'd10) ? 4'd1 : 4'd0, 4'((b >= 5'd10) ? b - 5'd10 : b)};
  endfunction

endpackage

// File: rtl/cnt_div.sv
// Free-running 0..DIV-1 prescaler with synchronous clear, terminal-count and half-period flags.
module cnt_div #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tc,
  output logic o_half
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc   = (r_cnt == LAST);
  assign o_half = (r_cnt >= HALF);

endmodule

// File: rtl/seg7dec.sv
// BCD to active-low 7-segment decoder, bit0 = a ... bit6 = g.
module seg7dec (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    unique case (i_bcd)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/clock_hms.sv
// BCD hours:minutes:seconds clock with set-mode FSM, blinking field and 12/24-hour display.
module clock_hms import clock_pkg::*; #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter bit          MODE24 = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SET,
  input  logic       INC,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       PM,
  output logic       TICK
);

  state_e     r_state, w_state_d;
  logic [7:0] r_sec, w_sec_d;  // {tens, units}
  logic [7:0] r_min, w_min_d;
  logic [7:0] r_hr, w_hr_d;
  logic       w_clr, w_tc, w_half, w_blink;
  logic [8:0] w_sec_inc, w_min_inc;
  logic [7:0] w_hr_inc, w_hr_disp;
  logic [6:0] w_seg [6];

  cnt_div #(
    .DIV(CLK_HZ)
  ) u_div (
    .i_clk (CLK),
    .i_rst (RST),
    .i_clr (w_clr),
    .o_tc  (w_tc),
    .o_half(w_half)
  );

  assign w_sec_inc = bcd60_inc(r_sec);
  assign w_min_inc = bcd60_inc(r_min);
  assign w_hr_inc  = bcd24_inc(r_hr);

  always_comb begin
    w_state_d = r_state;
    w_sec_d   = r_sec;
    w_min_d   = r_min;
    w_hr_d    = r_hr;
    w_clr     = 1'b0;
    if (SET) begin
      // SET has priority; a coincident INC is dropped.
      unique case (r_state)
        RUN:     w_state_d = SET_HR;
        SET_HR:  w_state_d = SET_MIN;
        SET_MIN: w_state_d = SET_SEC;
        SET_SEC: begin
          w_state_d = RUN;
          w_clr     = 1'b1;
        end
        default: w_state_d = RUN;
      endcase
    end else if (r_state == RUN) begin
      if (w_tc) begin
        w_sec_d = w_sec_inc[7:0];
        if (w_sec_inc[8]) begin
          w_min_d = w_min_inc[7:0];
          if (w_min_inc[8]) w_hr_d = w_hr_inc;
        end
      end
    end else if (INC) begin
      unique case (r_state)
        SET_HR:  w_hr_d  = w_hr_inc;
        SET_MIN: w_min_d = w_min_inc[7:0];
        SET_SEC: w_sec_d = w_sec_inc[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= RUN;
      r_sec   <= 8'h00;
      r_min   <= 8'h00;
      r_hr    <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_sec   <= w_sec_d;
      r_min   <= w_min_d;
      r_hr    <= w_hr_d;
    end
  end

  assign w_hr_disp = MODE24 ? r_hr : hr_to_12(r_hr);

  seg7dec u_seg0 (.i_bcd(r_sec[3:0]),     .o_seg(w_seg[0]));
  seg7dec u_seg1 (.i_bcd(r_sec[7:4]),     .o_seg(w_seg[1]));
  seg7dec u_seg2 (.i_bcd(r_min[3:0]),     .o_seg(w_seg[2]));
  seg7dec u_seg3 (.i_bcd(r_min[7:4]),     .o_seg(w_seg[3]));
  seg7dec u_seg4 (.i_bcd(w_hr_disp[3:0]), .o_seg(w_seg[4]));
  seg7dec u_seg5 (.i_bcd(w_hr_disp[7:4]), .o_seg(w_seg[5]));

  assign w_blink = w_half && (r_state != RUN);

  always_comb begin
    HEX0 = (w_blink && r_state == SET_SEC) ? SEG_BLANK : w_seg[0];
    HEX1 = (w_blink && r_state == SET_SEC) ? SEG_BLANK : w_seg[1];
    HEX2 = (w_blink && r_state == SET_MIN) ? SEG_BLANK : w_seg[2];
    HEX3 = (w_blink && r_state == SET_MIN) ? SEG_BLANK : w_seg[3];
    HEX4 = (w_blink && r_state == SET_HR)  ? SEG_BLANK : w_seg[4];
    // Leading zero of the hour is suppressed only in 12-hour mode.
    HEX5 = ((w_blink && r_state == SET_HR) || (!MODE24 && w_hr_disp[7:4] == 4'd0)) ?
           SEG_BLANK : w_seg[5];
  end

  assign PM   = !MODE24 && (r_hr >= 8'h12);
  assign TICK = w_tc && (r_state == RUN);

endmodule

// File: tb/tb_clock_hms.sv
// Directed bench for clock_hms: a 24-hour and a 12-hour instance share the same stimulus.
module tb_clock_hms;

  localparam int unsigned HZ = 10;

  logic       CLK = 1'b0;
  logic       RST, SET, INC;
  logic [6:0] hx24 [6];
  logic [6:0] hx12 [6];
  logic       pm24, pm12, tk24, tk12;

  int n_cmp = 0;
  int n_bad = 0;
  int st    = 0;  // expected FSM: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
  int pc    = 0;  // expected prescaler count

  clock_hms #(.CLK_HZ(HZ), .MODE24(1'b1)) dut24 (
    .CLK(CLK), .RST(RST), .SET(SET), .INC(INC),
    .HEX0(hx24[0]), .HEX1(hx24[1]), .HEX2(hx24[2]), .HEX3(hx24[3]), .HEX4(hx24[4]),
    .HEX5(hx24[5]), .PM(pm24), .TICK(tk24)
  );

  clock_hms #(.CLK_HZ(HZ), .MODE24(1'b0)) dut12 (
    .CLK(CLK), .RST(RST), .SET(SET), .INC(INC),
    .HEX0(hx12[0]), .HEX1(hx12[1]), .HEX2(hx12[2]), .HEX3(hx12[3]), .HEX4(hx12[4]),
    .HEX5(hx12[5]), .PM(pm12), .TICK(tk12)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input int hr, input int mn, input int sc, input bit m24,
                                          input bit b_hr, input bit b_mn, input bit b_sc);
    int dh;
    logic [6:0] d0, d1, d2, d3, d4, d5;
    dh = hr;
    if (!m24) begin
      dh = hr % 12;
      if (dh == 0) dh = 12;
    end
    d0 = b_sc ? 7'h7F : seg(sc % 10);
    d1 = b_sc ? 7'h7F : seg(sc / 10);
    d2 = b_mn ? 7'h7F : seg(mn % 10);
    d3 = b_mn ? 7'h7F : seg(mn / 10);
    d4 = b_hr ? 7'h7F : seg(dh % 10);
    d5 = (b_hr || (!m24 && dh < 10)) ? 7'h7F : seg(dh / 10);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic check(input string nm, input int hr, input int mn, input int sc, input bit tk);
    bit bl;
    bl = (st != 0) && (pc >= HZ / 2);
    cmp({nm, "/hex24"}, {hx24[5], hx24[4], hx24[3], hx24[2], hx24[1], hx24[0]},
        exp_hex(hr, mn, sc, 1'b1, bl && st == 1, bl && st == 2, bl && st == 3));
    cmp({nm, "/hex12"}, {hx12[5], hx12[4], hx12[3], hx12[2], hx12[1], hx12[0]},
        exp_hex(hr, mn, sc, 1'b0, bl && st == 1, bl && st == 2, bl && st == 3));
    cmp({nm, "/pm"}, {pm24, pm12}, {1'b0, hr >= 12});
    cmp({nm, "/tick"}, {tk24, tk12}, {tk, tk});
  endtask

  // One clock with SET/INC held across the edge; outputs then settle before checking.
  task automatic cyc(input bit s, input bit i);
    SET = s;
    INC = i;
    @(posedge CLK);
    #1;
    SET = 1'b0;
    INC = 1'b0;
    if (s && st == 3) pc = 0;
    else pc = (pc == HZ - 1) ? 0 : pc + 1;
    if (s) st = (st + 1) % 4;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    RST = 1'b1;
    SET = 1'b0;
    INC = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    st  = 0;
    pc  = 0;
  endtask

  typedef struct {
    bit s;
    bit i;
    int hr;
    int mn;
    int sc;
  } vec_t;

  vec_t tbl [11];
  int   blanks;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 0};  // into SET_HR
    tbl[1]  = '{1'b0, 1'b1, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 2, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 3, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 4, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 5, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 5, 0, 0};  // SET beats INC: to SET_MIN, hours kept
    tbl[7]  = '{1'b0, 1'b1, 5, 1, 0};
    tbl[8]  = '{1'b1, 1'b0, 5, 1, 0};  // into SET_SEC
    tbl[9]  = '{1'b0, 1'b1, 5, 1, 1};
    tbl[10] = '{1'b1, 1'b0, 5, 1, 1};  // back to RUN, prescaler cleared

    RST = 1'b1;
    SET = 1'b0;
    INC = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset", 0, 0, 0, 1'b0);
    cmp("reset/hex24_zero", {hx24[5], hx24[0]}, {7'b1000000, 7'b1000000});
    cmp("reset/hex12_twelve", {hx12[5], hx12[4]}, {7'b1111001, 7'b0100100});
    RST = 1'b0;

    for (int k = 0; k < 11; k++) begin
      cyc(tbl[k].s, tbl[k].i);
      check($sformatf("tbl%0d", k), tbl[k].hr, tbl[k].mn, tbl[k].sc, 1'b0);
    end

    // First tick after leaving set mode is a full CLK_HZ cycles away.
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("pre%0d", k), 5, 1, 1, k == 9);
    end
    cyc(1'b0, 1'b0);
    check("pre_step", 5, 1, 2, 1'b0);

    // Asynchronous reset in the middle of a set sequence.
    cyc(1'b1, 1'b0);
    check("async_sethr", 5, 1, 2, 1'b0);
    cyc(1'b0, 1'b1);
    check("async_inc", 6, 1, 2, 1'b0);
    #2;
    RST = 1'b1;
    st  = 0;
    pc  = 0;
    #1;
    check("async_rst", 0, 0, 0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Minutes wrap without carrying into hours, then freeze and blink.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("min_enter", 0, 0, 0, 1'b0);
    for (int k = 1; k <= 61; k++) begin
      cyc(1'b0, 1'b1);
      check($sformatf("min_inc%0d", k), 0, k % 60, 0, 1'b0);
    end
    blanks = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("freeze%0d", k), 0, 1, 0, 1'b0);
      if (hx24[3] == 7'h7F) blanks++;
    end
    cmp("blink_count", 64'(blanks), 64'd15);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("min_exit", 0, 1, 0, 1'b0);

    // Load 23:59:59 through the set path and roll over.
    do_reset();
    cyc(1'b1, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      cyc(1'b0, 1'b1);
      check($sformatf("hr_inc%0d", k), k, 0, 0, 1'b0);
    end
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 59; k++) cyc(1'b0, 1'b1);
    check("load_min", 23, 59, 0, 1'b0);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 59; k++) cyc(1'b0, 1'b1);
    check("load_sec", 23, 59, 59, 1'b0);
    cyc(1'b1, 1'b0);
    check("load_exit", 23, 59, 59, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("carry%0d", k), 23, 59, 59, k == 9);
    end
    cyc(1'b0, 1'b0);
    check("carry_wrap", 0, 0, 0, 1'b0);
    cmp("carry_hex24", {hx24[5], hx24[4], hx24[3], hx24[2], hx24[1], hx24[0]},
        {6{7'b1000000}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_hms.md
# clock_hms

Parametrised hours:minutes:seconds clock, successor to the two-digit seconds counter. It counts 00:00:00 through 23:59:59 in BCD from an internal prescaler, and offers a 12/24-hour display mode and a button-driven time-set state machine with a blinking selected field. Six decoded 7-segment digits drive HEX0–HEX5 directly at top level.

## Interface
- CLK_HZ, 50_000_000: CLK frequency; prescaler divides by this to get 1 Hz.
- MODE24, 1: 1 = 24-hour display; 0 = 12-hour display with PM flag.
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, asynchronous, active-high.
- SET  in  1  single-cycle pulse, synchronous to CLK, already debounced; advances set mode.
- INC  in  1  single-cycle pulse, synchronous to CLK, already debounced; increments selected field.
- HEX0 out 7  seconds units; active-low segments, bit0 = a … bit6 = g.
- HEX1 out 7  seconds tens.
- HEX2 out 7  minutes units.
- HEX3 out 7  minutes tens.
- HEX4 out 7  hours units.
- HEX5 out 7  hours tens.
- PM   out 1  high when hour ≥ 12 and MODE24 = 0; always 0 when MODE24 = 1.
- TICK out 1  one-cycle pulse on each counted second in RUN.

## Operation
- Time registers:
  - sec_u/sec_t: 0–9 / 0–5.
  - min_u/min_t: 0–9 / 0–5.
  - hr: stored 24-hour BCD, 00–23.
  - All are 4-bit BCD.
- Reset: all time fields 0, FSM = RUN, prescaler 0, TICK 0.
  - Reset display in 24-hour mode: 00:00:00, each digit 7'b1000000.
  - Reset display in 12-hour mode: 12:00:00, PM 0.
- Prescaler counts 0…CLK_HZ-1 continuously. tick_int is asserted when count = CLK_HZ-1.
- RUN:
  - On tick_int, seconds increment.
  - 59 s wraps to 00 and carries into minutes in the same cycle.
  - 59 min wraps and carries into hours.
  - 23:59:59 goes to 00:00:00 in one cycle.
  - TICK = tick_int.
- FSM states and transitions on SET: RUN → SET_HR → SET_MIN → SET_SEC → RUN.
- In any SET_* state:
  - tick_int is ignored; time is frozen and TICK = 0.
  - INC increments only the selected field, with wrap and no carry: hr 23 → 00, min 59 → 00, sec 59 → 00.
- INC in RUN is ignored.
- SET and INC in the same cycle: SET wins, INC is dropped.
- Transition SET_SEC → RUN clears the prescaler to 0, so the first post-set tick comes exactly CLK_HZ cycles later.
- Blink: in SET_* states, the selected digit pair outputs 7'h7F (blank) while prescaler count ≥ CLK_HZ/2. Other digits stay lit.
- 12-hour display mapping (internal storage stays 24-hour):
  - hr 00 displays 12.
  - hr 13–23 display 01–11.
  - hr 12 displays 12 with PM = 1.
  - Hours tens digit is blanked (7'h7F) when it is 0.
- RST asserted mid-operation, including during a set state: immediate return to the reset state, regardless of CLK.

## Timing
- All state is updated on posedge CLK or asynchronously on RST. No other clocks or enables.
- HEX*/PM are combinational decodes of registered fields; they change in the same cycle the field register updates, with no added latency.
- Increment latency:
  - The time register updates on the edge where tick_int is high.
  - TICK is high for exactly that one cycle.
- INC takes effect on the edge where it is sampled high. Back-to-back INC pulses give one increment each.
- SET takes effect on the edge where it is sampled high. The state is visible the next cycle.
- Tick period in RUN: exactly CLK_HZ cycles; no drift across carries.

## Structure
- Package clock_pkg:
  - FSM enum {RUN, SET_HR, SET_MIN, SET_SEC}.
  - SEG_BLANK = 7'h7F.
  - BCD limit constants (9, 5, 23).
  - 12-hour mapping function.
- Sub-module cnt_div #(DIV): prescaler with synchronous clear input. Outputs a terminal-count pulse and a ≥ DIV/2 half-flag.
- Reuse the existing seg7dec, six instances. Blanking is a mux after the decoder.

## Test plan
- Reset check: CLK_HZ=10, MODE24=1, assert RST for 3 cycles → HEX5..0 all 7'b1000000, TICK 0, PM 0.
- Carry chain: in RUN, load 23:59:59 via the set path, exit, wait 10 cycles → one TICK, display 00:00:00 in a single cycle.
- Set FSM:
  - SET, then 5×INC → hours 05.
  - SET, then 61×INC → minutes 01 (wrap, no carry into hours).
  - SET, SET → RUN.
  - Prescaler cleared: first TICK exactly 10 cycles after returning to RUN.
- Freeze and blink: in SET_MIN, 30 cycles → time unchanged, no TICK. HEX3/HEX2 read 7'h7F when prescaler ≥ 5, else digits; other digits constant.
- 12-hour mode (MODE24=0): set hr 00 → HEX5 blank, HEX4 "2"? No — shows 12 (HEX5 "1", HEX4 "2"), PM 0. Set hr 13 → HEX5 blank, HEX4 "1", PM 1.
- Collision and async reset:
  - SET and INC in the same cycle in SET_HR → state SET_MIN, hours unchanged.
  - Assert RST between edges mid-set → outputs reach reset values before the next edge.
